// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;

  localparam int FQ_XLEN = 32;
  localparam int FQ_DEPTH = 4;
  localparam logic [FQ_XLEN-1:0] FQ_RST_ADDR = '0;
  localparam int INSTR_BYTES = 4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fq_entry_t;

  // Clear the byte-offset bits so a redirect always lands on a word boundary.
  function automatic logic [FQ_XLEN-1:0] align_word(input logic [FQ_XLEN-1:0] addr);
    return addr & ~FQ_XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the memory, redirect and decode-side signals of the fetch queue.
interface fetch_queue_if #(
  parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH
) ();

  localparam int XLEN = fetch_queue_pkg::FQ_XLEN;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;
  logic [CW-1:0]   count;

  // The fetch queue itself.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready,
    output count
  );

  // Memory, writeback and decode around the queue.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready,
    input  count
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; head is readable combinationally.
module fetch_queue_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  T                             din,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW-1:0]  wr_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic [CW-1:0]  count_next;
  logic           do_push;
  logic           do_pop;

  // Pop only real entries; a push at full is accepted only alongside a pop.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage: each slot is written only when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Capture incoming entry into this slot.
      always_ff @(posedge clk) begin
        if (do_push && !flush && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, tracks the one in-flight
// memory read and buffers returned words for decode. Redirects flush everything.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int               DEPTH    = FQ_DEPTH,
  parameter logic [FQ_XLEN-1:0] RST_ADDR = FQ_RST_ADDR
) (
  input  logic          clk,
  input  logic          rst_n,   // active-high synchronous reset
  fetch_queue_if.master bus
);

  localparam int XLEN = FQ_XLEN;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  logic            has_head;
  fq_entry_t       push_entry;
  fq_entry_t       head;

  // Occupancy counts the in-flight read so a returning word always has a slot.
  // A pop this cycle is deliberately not credited until the next cycle.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue     = !bus.redirect_valid && (occupancy < DEPTH_LIM);
  assign push      = inflight_q && !bus.redirect_valid;
  assign has_head  = (count != '0);
  assign pop       = bus.out_valid && bus.out_ready;

  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = bus.imem_rdata;

  // Fetch PC and in-flight tracking; redirect drops the outstanding read.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q          <= RST_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (bus.redirect_valid) begin
      pc_q       <= align_word(bus.redirect_pc);
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + XLEN'(INSTR_BYTES);
      end
    end
  end

  fetch_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fq_entry_t)
  ) u_fifo (
    .clk   (clk),
    .srst  (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  assign bus.imem_addr = pc_q;
  assign bus.count     = count;
  assign bus.out_valid = has_head && !bus.redirect_valid;
  assign bus.out_pc    = has_head ? head.pc : '0;
  assign bus.out_instr = has_head ? head.instr : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a 1-cycle-latency instruction memory.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] mem_rdata = '0;

  fetch_queue_if #(.DEPTH(4)) bus ();

  always #5 clk = ~clk;

  // Instruction memory: word derived from the address, one cycle later.
  always @(posedge clk) mem_rdata <= bus.imem_addr ^ KEY;
  assign bus.imem_rdata = mem_rdata;

  fetch_queue #(.DEPTH(4), .RST_ADDR(32'h0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic do_reset();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h500;
    next_cycle();
    @(negedge clk);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.imem_addr); end
    total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", bus.out_pc); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", bus.out_instr); end
    next_cycle();
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_over_redirect got=%h want=0", bus.imem_addr); end
    $display("reset checked");
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== (k >= 2)) begin
        bad++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", k, bus.out_valid, (k >= 2));
      end
      if (k >= 2) begin
        exp_pc = 32'((k - 2) * 4);
        total++; if (bus.out_pc !== exp_pc) begin bad++; $display("FAIL stream_pc got=%h want=%h", bus.out_pc, exp_pc); end
        total++; if (bus.out_instr !== (exp_pc ^ KEY)) begin bad++; $display("FAIL stream_instr got=%h want=%h", bus.out_instr, exp_pc ^ KEY); end
        $display("pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    int n;
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) next_cycle();
    @(negedge clk);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL stall_count got=%0d want=4", bus.count); end
    total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL stall_addr got=%h want=10", bus.imem_addr); end
    total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL stall_head got=%h want=0", bus.out_pc); end
    next_cycle();
    bus.out_ready = 1'b1;
    exp_pc = 32'h0;
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        total++; if (bus.out_pc !== exp_pc) begin bad++; $display("FAIL stall_pc got=%h want=%h", bus.out_pc, exp_pc); end
        total++; if (bus.out_instr !== (exp_pc ^ KEY)) begin bad++; $display("FAIL stall_instr got=%h want=%h", bus.out_instr, exp_pc ^ KEY); end
        $display("pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc += 32'd4;
        n++;
      end
      next_cycle();
    end
    total++; if (n != 6) begin bad++; $display("FAIL stall_drain_timeout got=%0d want=6", n); end
  endtask

  task automatic test_redirect_flush();
    logic [31:0] exp_pc;
    int n;
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    @(negedge clk);
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d want=3", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_redir_valid got=%b want=0", bus.out_valid); end
    next_cycle();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", bus.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL flush_addr got=%h want=100", bus.imem_addr); end
    next_cycle();
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%b want=0", bus.out_valid); end
    next_cycle();
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL flush_first_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_pc !== 32'h100) begin bad++; $display("FAIL flush_first_pc got=%h want=100", bus.out_pc); end
    $display("pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
    next_cycle();
    exp_pc = 32'h104;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        total++; if (bus.out_pc !== exp_pc) begin bad++; $display("FAIL flush_pc got=%h want=%h", bus.out_pc, exp_pc); end
        $display("pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc += 32'd4;
        n++;
      end
      next_cycle();
    end
    total++; if (n != 3) begin bad++; $display("FAIL flush_timeout got=%0d want=3", n); end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] exp_pc;
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    @(negedge clk);
    total++; if (bus.out_pc !== 32'h8) begin bad++; $display("FAIL rpop_head got=%h want=8", bus.out_pc); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rpop_valid got=%b want=0", bus.out_valid); end
    next_cycle();
    bus.redirect_valid = 1'b0;
    exp_pc = 32'h40;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        total++; if (bus.out_pc !== exp_pc) begin bad++; $display("FAIL rpop_pc got=%h want=%h", bus.out_pc, exp_pc); end
        total++; if (bus.out_instr !== (exp_pc ^ KEY)) begin bad++; $display("FAIL rpop_instr got=%h want=%h", bus.out_instr, exp_pc ^ KEY); end
        $display("pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc += 32'd4;
        n++;
      end
      next_cycle();
    end
    total++; if (n != 3) begin bad++; $display("FAIL rpop_timeout got=%0d want=3", n); end
  endtask

  task automatic test_back_to_back_redirect();
    logic [31:0] exp_pc;
    int n;
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    next_cycle();
    bus.redirect_pc = 32'h302;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b want=0", bus.out_valid); end
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h300) begin bad++; $display("FAIL b2b_addr got=%h want=300", bus.imem_addr); end
    exp_pc = 32'h300;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      if (c != 0) @(negedge clk);
      if (bus.out_valid) begin
        total++; if (bus.out_pc !== exp_pc) begin bad++; $display("FAIL b2b_pc got=%h want=%h", bus.out_pc, exp_pc); end
        $display("pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc += 32'd4;
        n++;
      end
      next_cycle();
    end
    total++; if (n != 3) begin bad++; $display("FAIL b2b_timeout got=%0d want=3", n); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp_pc;
    int n;
    int first;
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) next_cycle();
    @(negedge clk);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL mreset_full got=%0d want=4", bus.count); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL mreset_count got=%0d want=0", bus.count); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL mreset_addr got=%h want=0", bus.imem_addr); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mreset_valid got=%b want=0", bus.out_valid); end
    exp_pc = 32'h0;
    n = 0;
    first = -1;
    for (int c = 0; c < 12 && n < 3; c++) begin
      if (c != 0) @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) first = c;
        total++; if (bus.out_pc !== exp_pc) begin bad++; $display("FAIL mreset_pc got=%h want=%h", bus.out_pc, exp_pc); end
        $display("pop pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc += 32'd4;
        n++;
      end
      next_cycle();
    end
    total++; if (first != 2) begin bad++; $display("FAIL mreset_latency got=%0d want=2", first); end
    total++; if (n != 3) begin bad++; $display("FAIL mreset_timeout got=%0d want=3", n); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_pop();
    test_back_to_back_redirect();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
